barcodescanner_run_capture: RTL and testbench

// Upstream producer for the scan buffer RAM. Samples the raw optical sensor line, filters glitches,
// and measures each bar/space run length in clock cycles. Writes one 32-bit word per run

---
 rtl/barcodescanner_run_capture.sv | 133 +++++++++++++
 tb/tb_barcodescanner_run_capture.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/barcodescanner_run_capture.sv
// rtl/barcodescanner_run_capture.sv - sensor run-length capture into scan buffer RAM port s2
// Synchronizes and deglitches scan_in, then writes one {level,len} word per bar/space run.
module barcodescanner_run_capture #(
  parameter int ADDR_W       = 7,
  parameter int DEPTH        = 100,
  parameter int CNT_W        = 24,
  parameter int MIN_RUN      = 4,
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scan_in,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_writedata,
  output logic              ram_write,
  output logic              ram_chipselect,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] run_count
);

  localparam int FC_W = $clog2(MIN_RUN + 1);
  localparam logic [CNT_W-1:0]  LEN_MAX  = '1;
  localparam logic [CNT_W-1:0]  LEN_TO   = CNT_W'(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              sync_1, sync_2, filt, filt_d;
  logic [FC_W-1:0]   flt_cnt;
  logic [CNT_W-1:0]  len;
  logic              filt_edge, arm, do_write;

  assign filt_edge      = filt ^ filt_d;
  assign busy           = (state == S_ARM) || (state == S_RUN);
  assign ram_chipselect = ram_write;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;

  // filt follows sync_2 only after MIN_RUN consecutive disagreeing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      flt_cnt <= '0;
    end else begin
      sync_1 <= scan_in;
      sync_2 <= sync_1;
      filt_d <= filt;
      if (sync_2 != filt) begin
        if (flt_cnt == FC_W'(MIN_RUN - 1)) begin
          filt    <= sync_2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    do_write  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_ARM;
          arm       = 1'b1;
        end
      end
      S_ARM: begin
        if (filt_edge) state_nxt = S_RUN;
      end
      S_RUN: begin
        // an edge beats a coincident timeout
        if (filt_edge) begin
          do_write = 1'b1;
          if (run_count == LAST_IDX) state_nxt = S_DONE;
        end else if (len == LEN_TO) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len           <= '0;
      ram_write     <= 1'b0;
      ram_writedata <= '0;
      ram_address   <= '0;
      run_count     <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      ram_write <= do_write;
      if (do_write) ram_writedata <= {filt_d, 7'b0, 24'(len)};

      if (state == S_ARM || do_write)             len <= CNT_W'(1);
      else if (state == S_RUN && len != LEN_MAX)  len <= len + 1'b1;

      // address lags the write strobe by one cycle and parks on the last word
      if (arm)                                        ram_address <= '0;
      else if (ram_write && ram_address != LAST_IDX)  ram_address <= ram_address + 1'b1;

      if (arm)           run_count <= '0;
      else if (do_write) run_count <= run_count + 1'b1;

      if (arm)                                          done <= 1'b0;
      else if (state == S_RUN && state_nxt == S_DONE)   done <= 1'b1;

      if (arm)                                      overflow <= 1'b0;
      else if (do_write && run_count == LAST_IDX)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_barcodescanner_run_capture.sv
// tb/tb_barcodescanner_run_capture.sv - scoreboard bench for barcodescanner_run_capture
// Expected RAM writes are queued as stimulus is issued; a negedge monitor pops and compares.
module tb_barcodescanner_run_capture;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 100;
  localparam int TO     = 1000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              scan_in = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_writedata;
  logic              ram_write, ram_chipselect, ram_clken;
  logic [3:0]        ram_byteenable;
  logic              busy, done, overflow;
  logic [ADDR_W-1:0] run_count;

  int checks = 0;
  int errors = 0;
  logic [38:0] sb[$];

  barcodescanner_run_capture #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(24), .MIN_RUN(4), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scan_in(scan_in), .start(start),
    .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_write(ram_write),
    .ram_chipselect(ram_chipselect), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .busy(busy), .done(done), .overflow(overflow), .run_count(run_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && ram_write) begin
      check("chipselect", 39'(ram_chipselect), 39'd1);
      if (sb.size() == 0) begin
        check("unexpected_write", {ram_address, ram_writedata}, 39'h0);
        if ({ram_address, ram_writedata} == 39'h0) begin
          errors++;
          $display("FAIL unexpected_write actual=write expected=none");
        end
      end else begin
        check("ram_word", {ram_address, ram_writedata}, sb.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    scan_in = lvl;
    cyc(n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic expect_word(input int addr, input logic lvl, input int len);
    sb.push_back({7'(addr), lvl, 7'b0, 24'(len)});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc(1);
      n++;
    end
    check("done_reached", 39'(done), 39'd1);
  endtask

  initial begin
    // reset held while the sensor line toggles
    for (int i = 0; i < 8; i++) hold(i[0], 3);
    check("rst_write", 39'(ram_write), 39'd0);
    check("rst_done", 39'(done), 39'd0);
    check("rst_busy", 39'(busy), 39'd0);
    check("rst_count", 39'(run_count), 39'd0);
    check("rst_ovf", 39'(overflow), 39'd0);
    check("rst_be", 39'(ram_byteenable), 39'hF);
    check("rst_clken", 39'(ram_clken), 39'd1);
    scan_in = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);

    // basic scan
    pulse_start();
    check("arm_busy", 39'(busy), 39'd1);
    expect_word(0, 1'b1, 10);
    expect_word(1, 1'b0, 20);
    expect_word(2, 1'b1, 30);
    hold(1'b0, 100); hold(1'b1, 10); hold(1'b0, 20); hold(1'b1, 30); hold(1'b0, TO + 200);
    wait_done(200);
    check("basic_count", 39'(run_count), 39'd3);
    check("basic_ovf", 39'(overflow), 39'd0);
    check("basic_busy", 39'(busy), 39'd0);
    check("basic_drained", 39'(sb.size()), 39'd0);

    // restart, then a glitch inside a space
    pulse_start();
    check("restart_done", 39'(done), 39'd0);
    check("restart_count", 39'(run_count), 39'd0);
    expect_word(0, 1'b1, 12);
    expect_word(1, 1'b0, 22);
    expect_word(2, 1'b1, 15);
    hold(1'b0, 50); hold(1'b1, 12); hold(1'b0, 10); hold(1'b1, 2); hold(1'b0, 10);
    hold(1'b1, 15); hold(1'b0, TO + 200);
    wait_done(200);
    check("glitch_count", 39'(run_count), 39'd3);

    // overflow: 101 runs of 8, only 100 words land
    pulse_start();
    hold(1'b0, 20);
    for (int i = 0; i < 101; i++) begin
      if (i < DEPTH) expect_word(i, (i % 2 == 0), 8);
      hold((i % 2 == 0), 8);
    end
    hold(1'b0, 50);
    check("ovf_flag", 39'(overflow), 39'd1);
    check("ovf_done", 39'(done), 39'd1);
    check("ovf_count", 39'(run_count), 39'(DEPTH));
    check("ovf_addr", 39'(ram_address), 39'(DEPTH - 1));
    check("ovf_drained", 39'(sb.size()), 39'd0);

    // start mid-RUN is ignored; reset mid-RUN drops everything pending
    pulse_start();
    expect_word(0, 1'b1, 10);
    expect_word(1, 1'b0, 20);
    hold(1'b0, 30); hold(1'b1, 10);
    hold(1'b0, 5); pulse_start(); hold(1'b0, 14);
    check("midrun_busy", 39'(busy), 39'd1);
    hold(1'b1, 12);
    check("midrun_count", 39'(run_count), 39'd2);
    reset_n = 1'b0;
    #1;
    check("rstrun_busy", 39'(busy), 39'd0);
    check("rstrun_count", 39'(run_count), 39'd0);
    hold(1'b0, 20);
    check("rstrun_write", 39'(ram_write), 39'd0);
    reset_n = 1'b1;
    hold(1'b1, 20);
    check("post_busy", 39'(busy), 39'd0);
    check("post_done", 39'(done), 39'd0);
    check("final_drained", 39'(sb.size()), 39'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
